// File: rtl/codeword_translator.sv
// Packet serialiser that drives an RF switch from a free-running square wave.
// A synchronised trigger edge starts a packet that phase-translates or gates ref_signal one payload bit at a time.
module codeword_translator #(
    parameter int DATA_W      = 10,
    parameter int SHIFT_DIV   = 2,
    parameter int BIT_CYCLES  = 20,
    parameter int START_DELAY = 40,
    parameter int MODE        = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              trigger_signal,
    input  logic [DATA_W-1:0] data_in,
    output logic              ref_signal,
    output logic              signal_into_switch,
    output logic              busy,
    output logic              done,
    output logic              RSS_EN
);

    if (DATA_W < 1 || DATA_W > 32) begin : g_bad_data_w
        $error("codeword_translator: DATA_W must be in 1..32");
    end
    if (SHIFT_DIV < 1) begin : g_bad_shift_div
        $error("codeword_translator: SHIFT_DIV must be at least 1");
    end
    if (BIT_CYCLES < 1) begin : g_bad_bit_cycles
        $error("codeword_translator: BIT_CYCLES must be at least 1");
    end
    if (START_DELAY < 0) begin : g_bad_start_delay
        $error("codeword_translator: START_DELAY must be at least 0");
    end
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
        $error("codeword_translator: MODE must be 0 or 1");
    end

    localparam int REF_W  = (SHIFT_DIV > 1)   ? $clog2(SHIFT_DIV)   : 1;
    localparam int BIT_W  = (BIT_CYCLES > 1)  ? $clog2(BIT_CYCLES)  : 1;
    localparam int IDX_W  = (DATA_W > 1)      ? $clog2(DATA_W)      : 1;
    localparam int WAIT_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(SHIFT_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_TX,
        S_DONE
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [1:0]          sync_reg;
    logic                trig_prev_reg;
    logic                trig_rise;
    logic [REF_W-1:0]    ref_cnt_reg;
    logic                ref_reg;
    logic [WAIT_W-1:0]   wait_cnt_reg;
    logic [BIT_W-1:0]    bit_cnt_reg;
    logic [IDX_W-1:0]    bit_idx_reg;
    logic [DATA_W-1:0]   shift_reg;
    logic                bit_end;
    logic                tx_bit;

    // Two-flop synchroniser; the extra flop only feeds the edge detector.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_reg      <= '0;
            trig_prev_reg <= 1'b0;
        end else begin
            sync_reg      <= {sync_reg[0], trigger_signal};
            trig_prev_reg <= sync_reg[1];
        end
    end

    assign trig_rise = sync_reg[1] & ~trig_prev_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ref_cnt_reg <= '0;
            ref_reg     <= 1'b0;
        end else if (ref_cnt_reg == REF_LAST) begin
            ref_cnt_reg <= '0;
            ref_reg     <= ~ref_reg;
        end else begin
            ref_cnt_reg <= ref_cnt_reg + REF_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign bit_end = (bit_cnt_reg == BIT_LAST);

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE: if (trig_rise) state_next = (START_DELAY == 0) ? S_TX : S_WAIT;
            S_WAIT: if (wait_cnt_reg == WAIT_LAST) state_next = S_TX;
            S_TX:   if (bit_end && bit_idx_reg == IDX_LAST) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Counters clear whenever their state is not active, so each starts at 0 on entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
        end else begin
            wait_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            bit_idx_reg  <= '0;
            unique case (state_reg)
                S_IDLE: if (trig_rise) shift_reg <= data_in;
                S_WAIT: if (wait_cnt_reg != WAIT_LAST) wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                S_TX: begin
                    bit_idx_reg <= bit_idx_reg;
                    if (!bit_end) begin
                        bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                    end else if (bit_idx_reg != IDX_LAST) begin
                        bit_idx_reg <= bit_idx_reg + IDX_W'(1);
                        shift_reg   <= shift_reg << 1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_bit = shift_reg[DATA_W-1];

    always_comb begin
        signal_into_switch = ref_reg;
        if (state_reg == S_TX) begin
            signal_into_switch = (MODE == 1) ? (ref_reg & tx_bit) : ~(ref_reg ^ tx_bit);
        end
    end

    assign ref_signal = ref_reg;
    assign busy       = (state_reg != S_IDLE);
    assign done       = (state_reg == S_DONE);
    assign RSS_EN     = 1'b1;

endmodule

// File: tb/tb_codeword_translator.sv
// Directed bench for codeword_translator: default, MODE=1 and zero-delay
// instances share clock and reset; expectations come from a cycle-count ref model.
module tb_codeword_translator;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       trig0 = 1'b0, trig1 = 1'b0, trig2 = 1'b0;
    logic [9:0] data0 = '0, data1 = '0;
    logic [3:0] data2 = '0;
    logic       ref0, sw0, busy0, done0, rss0;
    logic       ref1, sw1, busy1, done1, rss1;
    logic       ref2, sw2, busy2, done2, rss2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clock = ~clock;

    codeword_translator dut0 (
        .clock(clock), .reset(reset), .trigger_signal(trig0), .data_in(data0),
        .ref_signal(ref0), .signal_into_switch(sw0), .busy(busy0), .done(done0), .RSS_EN(rss0)
    );

    codeword_translator #(.MODE(1)) dut1 (
        .clock(clock), .reset(reset), .trigger_signal(trig1), .data_in(data1),
        .ref_signal(ref1), .signal_into_switch(sw1), .busy(busy1), .done(done1), .RSS_EN(rss1)
    );

    codeword_translator #(.DATA_W(4), .BIT_CYCLES(1), .START_DELAY(0)) dut2 (
        .clock(clock), .reset(reset), .trigger_signal(trig2), .data_in(data2),
        .ref_signal(ref2), .signal_into_switch(sw2), .busy(busy2), .done(done2), .RSS_EN(rss2)
    );

    // Expected ref_signal: 0 after reset release, toggling every 2 edges.
    function automatic logic exp_ref();
        return ((cyc / 2) % 2) == 1;
    endfunction

    function automatic logic get_ref(input int idx);
        case (idx)
            0: return ref0;
            1: return ref1;
            default: return ref2;
        endcase
    endfunction

    function automatic logic get_sw(input int idx);
        case (idx)
            0: return sw0;
            1: return sw1;
            default: return sw2;
        endcase
    endfunction

    function automatic logic get_busy(input int idx);
        case (idx)
            0: return busy0;
            1: return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic get_done(input int idx);
        case (idx)
            0: return done0;
            1: return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic get_rss(input int idx);
        case (idx)
            0: return rss0;
            1: return rss1;
            default: return rss2;
        endcase
    endfunction

    task automatic set_trig(input int idx, input logic v);
        case (idx)
            0: trig0 = v;
            1: trig1 = v;
            default: trig2 = v;
        endcase
    endtask

    task automatic set_data(input int idx, input logic [31:0] v);
        case (idx)
            0: data0 = v[9:0];
            1: data1 = v[9:0];
            default: data2 = v[3:0];
        endcase
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("idle_ref%0d", d), get_ref(d), exp_ref());
                chk($sformatf("idle_sw%0d", d), get_sw(d), exp_ref());
                chk($sformatf("idle_busy%0d", d), get_busy(d), 1'b0);
                chk($sformatf("idle_done%0d", d), get_done(d), 1'b0);
                chk($sformatf("idle_rss%0d", d), get_rss(d), 1'b1);
            end
        end
    endtask

    // Raises the trigger of instance idx and checks every cycle of the packet.
    task automatic run_pkt(input int idx, input logic [31:0] payload, input int dw, input int bc,
                           input int sd, input int mode, input bit hold_trig,
                           input int mid_at, input int abort_at);
        logic b;
        logic exp_sw;
        set_data(idx, payload);
        set_trig(idx, 1'b1);
        for (int e = 1; e <= 2; e++) begin
            tick();
            chk($sformatf("pre_busy%0d_e%0d", idx, e), get_busy(idx), 1'b0);
            chk($sformatf("pre_sw%0d_e%0d", idx, e), get_sw(idx), exp_ref());
        end
        tick();
        if (!hold_trig) set_trig(idx, 1'b0);
        for (int i = 0; i < sd; i++) begin
            chk($sformatf("wait_busy%0d_%0d", idx, i), get_busy(idx), 1'b1);
            chk($sformatf("wait_sw%0d_%0d", idx, i), get_sw(idx), exp_ref());
            chk($sformatf("wait_done%0d_%0d", idx, i), get_done(idx), 1'b0);
            tick();
        end
        for (int t = 0; t < dw * bc; t++) begin
            b = payload[dw - 1 - t / bc];
            exp_sw = (mode == 1) ? (exp_ref() & b) : ~(exp_ref() ^ b);
            chk($sformatf("tx_sw%0d_t%0d", idx, t), get_sw(idx), exp_sw);
            chk($sformatf("tx_busy%0d_t%0d", idx, t), get_busy(idx), 1'b1);
            chk($sformatf("tx_done%0d_t%0d", idx, t), get_done(idx), 1'b0);
            if (t == mid_at) begin
                set_trig(idx, 1'b1);
                set_data(idx, 32'h0);
            end
            if (mid_at >= 0 && t == mid_at + 2) set_trig(idx, 1'b0);
            if (t == abort_at) begin
                reset = 1'b1;
                #2;
                chk("abort_busy_async", get_busy(idx), 1'b0);
                chk("abort_done_async", get_done(idx), 1'b0);
                chk("abort_ref_async", get_ref(idx), 1'b0);
                chk("abort_sw_async", get_sw(idx), 1'b0);
                chk("abort_rss_async", get_rss(idx), 1'b1);
                @(posedge clock);
                #1;
                chk("abort_busy_held", get_busy(idx), 1'b0);
                chk("abort_done_held", get_done(idx), 1'b0);
                reset = 1'b0;
                cyc = 0;
                return;
            end
            tick();
        end
        chk($sformatf("done_pulse%0d", idx), get_done(idx), 1'b1);
        chk($sformatf("done_busy%0d", idx), get_busy(idx), 1'b1);
        chk($sformatf("done_sw%0d", idx), get_sw(idx), exp_ref());
        tick();
        chk($sformatf("post_done%0d", idx), get_done(idx), 1'b0);
        chk($sformatf("post_busy%0d", idx), get_busy(idx), 1'b0);
        chk($sformatf("post_sw%0d", idx), get_sw(idx), exp_ref());
    endtask

    initial begin
        #2;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_ref%0d", d), get_ref(d), 1'b0);
            chk($sformatf("rst_sw%0d", d), get_sw(d), 1'b0);
            chk($sformatf("rst_busy%0d", d), get_busy(d), 1'b0);
            chk($sformatf("rst_done%0d", d), get_done(d), 1'b0);
            chk($sformatf("rst_rss%0d", d), get_rss(d), 1'b1);
        end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        cyc = 0;
        $display("step: reset released, idle run");
        idle(10);

        $display("step: default packet 10'b1010101010");
        run_pkt(0, 32'h2AA, 10, 20, 40, 0, 1'b0, -1, -1);
        idle(5);

        $display("step: packet 10'h2d3 with trigger pulse and data change during TX");
        run_pkt(0, 32'h2D3, 10, 20, 40, 0, 1'b0, 50, -1);
        idle(10);

        $display("step: MODE=1 packet 10'h201");
        run_pkt(1, 32'h201, 10, 20, 40, 1, 1'b0, -1, -1);
        idle(3);

        $display("step: reset at TX cycle 57");
        run_pkt(0, 32'h0F3, 10, 20, 40, 0, 1'b0, -1, 57);
        idle(3);

        $display("step: full packet after abort 10'h35a");
        run_pkt(0, 32'h35A, 10, 20, 40, 0, 1'b0, -1, -1);
        idle(3);

        $display("step: zero-delay instance, trigger held high 50 cycles");
        run_pkt(2, 32'hB, 4, 1, 0, 0, 1'b1, -1, -1);
        idle(42);
        trig2 = 1'b0;
        idle(4);

        $display("step: zero-delay instance, second packet after new edge");
        run_pkt(2, 32'h6, 4, 1, 0, 0, 1'b0, -1, -1);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/codeword_translator.md
CODEWORD_TRANSLATOR -- requirements
Module: codeword_translator

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- DATA_W, 10, payload bits per packet, legal range 1..32.
- SHIFT_DIV, 2, clock cycles per ref_signal half-period, minimum 1.
- BIT_CYCLES, 20, clock cycles per payload bit, minimum 1.
- START_DELAY, 40, clock cycles from trigger acceptance to first bit, minimum 0.
- MODE, 0, 0 = XNOR phase translation, 1 = on-off gating.
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clock, in, 1, sole clock (PLL GLA domain).
- reset, in, 1, asynchronous, active-high.
- trigger_signal, in, 1, asynchronous packet-start indication.
- data_in, in, DATA_W, payload, sent MSB first.
- ref_signal, out, 1, frequency-shift square wave.
- signal_into_switch, out, 1, RF switch drive.
- busy, out, 1, packet in progress.
- done, out, 1, one-cycle end-of-packet pulse.
- RSS_EN, out, 1, constant 1.

Function
REQ-003 All logic SHALL run on clock only; no derived or gated clocks. Rate generation SHALL use counter-based enables.
REQ-004 ref_signal SHALL toggle every SHIFT_DIV cycles, free-running in all states.
REQ-005 trigger_signal SHALL pass through a 2-flop synchroniser followed by a rising-edge detector.
REQ-006 Packet acceptance (IDLE exit) SHALL occur on the 3rd rising clock edge, counting the edge that first samples trigger_signal high as the 1st.
REQ-007 FSM states SHALL be IDLE, WAIT, TX and DONE.
- IDLE -> WAIT on an accepted edge, or IDLE -> TX if START_DELAY=0.
- WAIT -> TX after START_DELAY cycles.
- TX -> DONE after DATA_W*BIT_CYCLES cycles.
- DONE -> IDLE after 1 cycle.
REQ-008 data_in SHALL be captured into a shift register on the IDLE-exit edge. Later changes to data_in SHALL have no effect on the packet in progress.
REQ-009 In TX, the current bit SHALL be the shift-register MSB, shifting left once every BIT_CYCLES cycles. Bit k SHALL occupy TX cycles k*BIT_CYCLES .. (k+1)*BIT_CYCLES-1.
REQ-010 busy SHALL be 1 in WAIT, TX and DONE, and 0 in IDLE. done SHALL be 1 only in DONE.
REQ-011 signal_into_switch SHALL equal ref_signal in IDLE, WAIT and DONE.
REQ-012 In TX, signal_into_switch SHALL be:
- MODE=0: ref_signal XNOR bit (bit 1 passes ref, bit 0 inverts it).
- MODE=1: ref_signal AND bit.
REQ-013 signal_into_switch SHALL be a function of registered state only, with no combinational path from any input.
REQ-014 Rising edges of trigger_signal while busy=1 SHALL be ignored and SHALL NOT be queued.
- A trigger held high across DONE SHALL NOT retrigger; a new rising edge is required.
REQ-015 Counter widths SHALL be sized with clog2 of their terminal count. Counters SHALL NOT wrap inside a state; each clears on state entry.
REQ-016 Out-of-range parameters SHALL cause an elaboration error.

Reset
REQ-017 reset=1 SHALL asynchronously force the following, independent of clock:
- FSM to IDLE; all counters, the shift register and the synchroniser to 0.
- ref_signal=0, signal_into_switch=0, busy=0, done=0; RSS_EN stays 1.
REQ-018 Reset asserted mid-packet SHALL abort the packet with no done pulse.
- After reset release, ref_signal SHALL restart from 0 and its first toggle SHALL occur SHIFT_DIV cycles later.

Verification
REQ-019 Apply reset, release, then run 10 cycles -> ref_signal toggles every 2 cycles starting from 0; signal_into_switch tracks ref_signal; busy=0; done=0; RSS_EN=1.
REQ-020 Trigger with data_in=10'b1010101010 under defaults -> busy rises on edge 3; TX starts 40 cycles later; switch equals ref for 20 cycles, then ~ref for 20 cycles, alternating for 200 cycles; single done pulse; busy high for 40+200+1 cycles.
REQ-021 During TX, pulse trigger_signal and change data_in to 10'h000 -> no restart, payload unchanged, exactly one done pulse.
REQ-022 MODE=1 with data_in=10'h201 -> switch equals ref for bit 0, held 0 for bits 1..8, equals ref for bit 9.
REQ-023 Assert reset at TX cycle 57 -> immediate IDLE, busy=0, no done pulse; a later trigger sends a full packet normally.
REQ-024 START_DELAY=0, DATA_W=4, BIT_CYCLES=1, trigger held high for 50 cycles -> TX begins on the IDLE-exit edge with 4 cycles of data; exactly one packet sent; a second packet only after trigger goes low then high again.
